// File: rtl/key_evt_pkg.sv
// key_evt_pkg: shared definitions for the key event controller.
//   EVT_PRESS / EVT_LONG / EVT_REPEAT : 2-bit event type codes (00 is never emitted)
//   chan_state_e                      : per-key channel FSM states
//   evt_t                             : FIFO entry {key index, event type}
//   cnt_width()                       : counter width for the largest cycle parameter
package key_evt_pkg;

    localparam logic [1:0] EVT_PRESS  = 2'b01;
    localparam logic [1:0] EVT_LONG   = 2'b10;
    localparam logic [1:0] EVT_REPEAT = 2'b11;

    // Storage width of the key index inside an event; the top narrows it
    // to $clog2(N_KEYS) at the output port.
    localparam int KEY_IDX_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEB,
        ST_HELD,
        ST_RPT
    } chan_state_e;

    typedef struct packed {
        logic [KEY_IDX_W-1:0] key;
        logic [1:0]           typ;
    } evt_t;

    // Counter values only ever reach (param - 1), so $clog2 of the largest
    // parameter is enough and the counter never wraps.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 2) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/key_evt_chan.sv
// key_evt_chan: debounce and press classification for one raw key line.
//   clk      : system clock
//   reset    : synchronous active-low reset
//   key_i    : raw key level, active-high, already synchronised
//   raise_o  : combinational one-cycle strobe, an event is produced at this edge
//   type_o   : event type accompanying raise_o (PRESS / LONG / REPEAT)
// Any low sample returns the channel to IDLE; release never produces an event.
module key_evt_chan
    import key_evt_pkg::*;
#(
    parameter int DEB_CYCLES  = 25000,
    parameter int LONG_CYCLES = 25000000,
    parameter int REP_CYCLES  = 5000000,
    parameter int CNT_W       = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_i,
    output logic       raise_o,
    output logic [1:0] type_o
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CYCLES - 1);

    chan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        raise_o = 1'b0;
        type_o  = EVT_PRESS;
        case (state_q)
            ST_IDLE: begin
                // The entering sample already counts as the first high sample.
                if (key_i) begin
                    state_d = ST_DEB;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_DEB: begin
                if (!key_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                    raise_o = 1'b1;
                    type_o  = EVT_PRESS;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HELD: begin
                if (!key_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = ST_RPT;
                    cnt_d   = '0;
                    raise_o = 1'b1;
                    type_o  = EVT_LONG;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RPT: begin
                if (!key_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == REP_LAST) begin
                    cnt_d   = '0;
                    raise_o = 1'b1;
                    type_o  = EVT_REPEAT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/key_event_ctrl.sv
// key_event_ctrl: multi-key debounce/classification with round-robin event FIFO.
//   clk        : system clock
//   reset      : synchronous active-low reset
//   key        : N_KEYS raw key levels, active-high
//   evt_valid  : FIFO head valid
//   evt_ready  : consumer accepts head when evt_valid && evt_ready
//   evt_key    : key index of head event
//   evt_type   : head event type (01 PRESS, 10 LONG, 11 REPEAT)
//   ovf        : sticky, an event was dropped because its key's slot was still full
//   ovf_clr    : clears ovf unless a drop happens in the same cycle
module key_event_ctrl
    import key_evt_pkg::*;
#(
    parameter int N_KEYS      = 4,
    parameter int DEB_CYCLES  = 25000,
    parameter int LONG_CYCLES = 25000000,
    parameter int REP_CYCLES  = 5000000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_KEYS-1:0]         key,
    output logic                      evt_valid,
    input  logic                      evt_ready,
    output logic [$clog2(N_KEYS)-1:0] evt_key,
    output logic [1:0]                evt_type,
    output logic                      ovf,
    input  logic                      ovf_clr
);

    localparam int KEY_W = $clog2(N_KEYS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = cnt_width(DEB_CYCLES, LONG_CYCLES, REP_CYCLES);
    localparam logic [PTR_W:0] FIFO_FULL = (PTR_W+1)'(FIFO_DEPTH);

    logic [N_KEYS-1:0] raise;
    logic [1:0]        ch_type [N_KEYS];

    for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
        key_evt_chan #(
            .DEB_CYCLES (DEB_CYCLES),
            .LONG_CYCLES(LONG_CYCLES),
            .REP_CYCLES (REP_CYCLES),
            .CNT_W      (CNT_W)
        ) u_chan (
            .clk    (clk),
            .reset  (reset),
            .key_i  (key[g]),
            .raise_o(raise[g]),
            .type_o (ch_type[g])
        );
    end

    logic [N_KEYS-1:0] pend_q, pend_d;
    logic [1:0]        ptype_q [N_KEYS];
    logic [1:0]        ptype_d [N_KEYS];
    logic [KEY_W-1:0]  rr_q, rr_d;
    logic              ovf_q, ovf_d;
    evt_t              mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_q, rd_q;
    logic [PTR_W:0]    fcnt_q;

    logic             pop, can_push, gnt_vld, drop;
    logic [KEY_W-1:0] gnt_idx;
    int               idx;
    evt_t             head, push_evt;

    // Round-robin arbiter: first pending key at or after rr_q wins. A full
    // FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        pop      = (fcnt_q != '0) && evt_ready;
        can_push = (fcnt_q != FIFO_FULL) || pop;
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        idx      = 0;
        for (int off = 0; off < N_KEYS; off++) begin
            idx = (int'(rr_q) + off) % N_KEYS;
            if (can_push && !gnt_vld && pend_q[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = KEY_W'(idx);
            end
        end
        rr_d = gnt_vld ? KEY_W'((int'(gnt_idx) + 1) % N_KEYS) : rr_q;
    end

    // Pending slots: a slot being granted this cycle can take a new event;
    // otherwise a second event on a full slot is lost and flagged.
    always_comb begin
        drop   = 1'b0;
        pend_d = pend_q;
        for (int i = 0; i < N_KEYS; i++) begin
            ptype_d[i] = ptype_q[i];
            if (gnt_vld && (gnt_idx == KEY_W'(i))) begin
                pend_d[i] = 1'b0;
            end
            if (raise[i]) begin
                if (pend_q[i] && !(gnt_vld && (gnt_idx == KEY_W'(i)))) begin
                    drop = 1'b1;
                end else begin
                    pend_d[i]  = 1'b1;
                    ptype_d[i] = ch_type[i];
                end
            end
        end
        // A drop in the same cycle as ovf_clr keeps the flag set.
        ovf_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
    end

    always_comb begin
        push_evt.key = KEY_IDX_W'(gnt_idx);
        push_evt.typ = ptype_q[gnt_idx];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pend_q <= '0;
            rr_q   <= '0;
            ovf_q  <= 1'b0;
            wr_q   <= '0;
            rd_q   <= '0;
            fcnt_q <= '0;
        end else begin
            pend_q <= pend_d;
            rr_q   <= rr_d;
            ovf_q  <= ovf_d;
            if (gnt_vld) wr_q <= wr_q + PTR_W'(1);
            if (pop)     rd_q <= rd_q + PTR_W'(1);
            case ({gnt_vld, pop})
                2'b10:   fcnt_q <= fcnt_q + (PTR_W+1)'(1);
                2'b01:   fcnt_q <= fcnt_q - (PTR_W+1)'(1);
                default: fcnt_q <= fcnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        ptype_q <= ptype_d;
        if (gnt_vld) mem_q[wr_q] <= push_evt;
    end

    // First-word-fall-through head; outputs forced to zero while empty so
    // stale storage never appears on the port.
    assign head      = mem_q[rd_q];
    assign evt_valid = (fcnt_q != '0);
    assign evt_key   = evt_valid ? head.key[KEY_W-1:0] : '0;
    assign evt_type  = evt_valid ? head.typ : 2'b00;
    assign ovf       = ovf_q;

    logic unused_head_key;
    assign unused_head_key = ^head.key;

endmodule

// File: tb/tb_key_event_ctrl.sv
module tb_key_event_ctrl;

    logic       clk;
    logic       reset;
    logic [3:0] key;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_key;
    logic [1:0] evt_type;
    logic       ovf;
    logic       ovf_clr;

    int n_tests;
    int n_fail;

    key_event_ctrl #(
        .N_KEYS     (4),
        .DEB_CYCLES (4),
        .LONG_CYCLES(10),
        .REP_CYCLES (3),
        .FIFO_DEPTH (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .key      (key),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_key  (evt_key),
        .evt_type (evt_type),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        key       = 4'b0000;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        step();
        reset = 1'b1;
    endtask

    logic       bounce [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [1:0] drain_key [7] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    logic [1:0] drain_typ [7] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10};

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b0;
        key       = 4'b0000;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_valid", evt_valid, 0);
        chk("rst_key", evt_key, 0);
        chk("rst_type", evt_type, 0);
        chk("rst_ovf", ovf, 0);
        reset = 1'b1;

        // Bounce: 1,1,1,0 then steady high; PRESS visible after 5th edge of the second burst
        for (int s = 1; s <= 9; s++) begin
            key[0] = bounce[s-1];
            step();
            chk($sformatf("bounce_valid_s%0d", s), evt_valid, (s == 9) ? 1 : 0);
        end
        chk("bounce_key", evt_key, 0);
        chk("bounce_type", evt_type, 2'b01);
        key       = 4'b0000;
        evt_ready = 1'b1;
        for (int s = 10; s <= 13; s++) begin
            step();
            chk($sformatf("bounce_after_s%0d", s), evt_valid, 0);
        end

        // Long hold on key 2 for 30 samples
        evt_ready = 1'b1;
        for (int s = 1; s <= 40; s++) begin
            logic exp_v;
            logic [1:0] exp_t;
            key = (s <= 30) ? 4'b0100 : 4'b0000;
            step();
            exp_v = (s == 5) || (s == 15) || (s >= 18 && s <= 30 && ((s - 18) % 3) == 0);
            exp_t = (s == 5) ? 2'b01 : ((s == 15) ? 2'b10 : 2'b11);
            chk($sformatf("long_valid_s%0d", s), evt_valid, exp_v);
            if (exp_v) begin
                chk($sformatf("long_key_s%0d", s), evt_key, 2);
                chk($sformatf("long_type_s%0d", s), evt_type, exp_t);
            end
        end
        chk("long_ovf", ovf, 0);

        // Simultaneous presses on all keys, delivered 0,1,2,3
        do_reset();
        chk("sim_rst_valid", evt_valid, 0);
        evt_ready = 1'b1;
        key       = 4'b1111;
        for (int s = 1; s <= 12; s++) begin
            if (s == 10) key = 4'b0000;
            step();
            chk($sformatf("sim_valid_s%0d", s), evt_valid, (s >= 5 && s <= 8) ? 1 : 0);
            if (s >= 5 && s <= 8) begin
                chk($sformatf("sim_key_s%0d", s), evt_key, s - 5);
                chk($sformatf("sim_type_s%0d", s), evt_type, 2'b01);
            end
        end

        // Backpressure and overflow
        do_reset();
        evt_ready = 1'b0;
        key       = 4'b1111;
        for (int s = 1; s <= 17; s++) begin
            step();
            chk($sformatf("bp_valid_s%0d", s), evt_valid, (s >= 5) ? 1 : 0);
            chk($sformatf("bp_ovf_s%0d", s), ovf, (s >= 17) ? 1 : 0);
        end
        chk("bp_head_key", evt_key, 0);
        chk("bp_head_type", evt_type, 2'b01);
        key       = 4'b0000;
        evt_ready = 1'b1;
        for (int s = 18; s <= 24; s++) begin
            step();
            chk($sformatf("drain_valid_s%0d", s), evt_valid, 1);
            chk($sformatf("drain_key_s%0d", s), evt_key, drain_key[s-18]);
            chk($sformatf("drain_type_s%0d", s), evt_type, drain_typ[s-18]);
        end
        step();
        chk("drain_empty", evt_valid, 0);
        chk("ovf_sticky", ovf, 1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_cleared", ovf, 0);

        // Reset while the FIFO holds three events
        do_reset();
        evt_ready = 1'b0;
        key       = 4'b0111;
        for (int s = 1; s <= 7; s++) step();
        chk("mid_valid_before", evt_valid, 1);
        chk("mid_key_before", evt_key, 0);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("mid_rst_valid", evt_valid, 0);
        chk("mid_rst_key", evt_key, 0);
        chk("mid_rst_type", evt_type, 0);
        chk("mid_rst_ovf", ovf, 0);
        for (int s = 9; s <= 13; s++) begin
            step();
            chk($sformatf("redeb_valid_s%0d", s), evt_valid, (s == 13) ? 1 : 0);
        end
        chk("redeb_key", evt_key, 0);
        chk("redeb_type", evt_type, 2'b01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
